// File: rtl/fp_newton_pkg.sv
// Shared types for the Newton-Raphson fraction divider: FSM states and the 1/b seed table.
package fp_newton_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_ITER_A,
    ST_ITER_B,
    ST_MUL,
    ST_DONE
  } state_t;

  // Entry i approximates 1/b - 1 (scaled by 256) for b in [0.5 + i/32, 0.5 + (i+1)/32).
  localparam logic [15:0][7:0] SEED_ROM = {
    8'h04, 8'h0c, 8'h15, 8'h1f, 8'h29, 8'h35, 8'h41, 8'h4e,
    8'h5c, 8'h6c, 8'h7d, 8'h8f, 8'ha4, 8'hba, 8'hd4, 8'hf0
  };

  function automatic logic [7:0] seed_lookup(input logic [3:0] idx);
    return SEED_ROM[idx];
  endfunction

endpackage

// File: rtl/fdiv_newton_mul.sv
// Combinational unsigned multiplier; the product is kept to its low PROD_W bits.
module fdiv_newton_mul #(
  parameter int DATA_W = 26,
  parameter int PROD_W = 50
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [PROD_W-1:0] o_p
);

  assign o_p = {{(PROD_W-DATA_W){1'b0}}, i_a} * {{(PROD_W-DATA_W){1'b0}}, i_b};

endmodule

// File: rtl/fdiv_newton_core.sv
// Iterative Newton-Raphson fraction divider: refines x ~ 1/b from a table seed, then q = a*x
// with a sticky LSB. One shared multiplier serves every step; one operation in flight at a time.
module fdiv_newton_core
  import fp_newton_pkg::*;
#(
  parameter int W    = 24,
  parameter int ITER = 3
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              a_frac,
  input  logic [W-1:0]              b_frac,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W+7:0]              q,
  output logic                      busy,
  output logic [$clog2(ITER+1)-1:0] iter
);

  localparam int XW = W + 2;
  localparam int IW = $clog2(ITER + 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(ITER);

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [XW-1:0]   r_x;
  logic [XW-1:0]   r_t;
  logic [W+7:0]    r_q;
  logic [IW-1:0]   r_iter;
  logic [XW-1:0]   w_mul_a;
  logic [XW-1:0]   w_mul_b;
  logic [2*W+1:0]  w_prod;
  logic [XW-1:0]   w_prod_mid;
  logic [XW-1:0]   w_t;
  logic [XW-1:0]   w_seed;
  logic [IW-1:0]   w_iter_inc;

  // Truncate a*x (bit 2W has weight 1) to 1.(W+6) and fold the discarded bits into a sticky LSB.
  function automatic logic [W+7:0] pack_q(input logic [2*W:0] p);
    return {p[2*W:W-6], |p[W-7:0]};
  endfunction

  fdiv_newton_mul #(
    .DATA_W (XW),
    .PROD_W (2*W + 2)
  ) u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  // Every product is re-read in 2.W format; 2 - b*x is formed as 2^(W+1) - (b*x).
  assign w_prod_mid = w_prod[2*W+1:W];
  assign w_t        = (XW'(1) << (W + 1)) - w_prod_mid;
  assign w_seed     = (XW'(1) << W) | (XW'(seed_lookup(r_b[W-2:W-5])) << (W - 8));
  assign w_iter_inc = r_iter + IW'(1);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    w_mul_a   = r_t;
    w_mul_b   = r_x;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = ST_SEED;
      end
      ST_SEED:   w_next = ST_ITER_A;
      ST_ITER_A: begin
        w_mul_a = {2'b00, r_b};
        w_next  = ST_ITER_B;
      end
      ST_ITER_B: w_next = (w_iter_inc == ITER_LAST) ? ST_MUL : ST_ITER_A;
      ST_MUL: begin
        w_mul_a = {2'b00, r_a};
        w_next  = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
    if (flush && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_q    <= '0;
      r_iter <= '0;
    end else if (!flush) begin
      case (r_state)
        ST_SEED:   r_iter <= '0;
        ST_ITER_B: r_iter <= w_iter_inc;
        ST_MUL:    r_q    <= pack_q(w_prod[2*W:0]);
        default:   ;
      endcase
    end
  end

  // Operand and iterate registers carry no reset; the FSM decides when they are meaningful.
  always_ff @(posedge clock) begin
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          r_a <= a_frac;
          r_b <= b_frac;
        end
      end
      ST_SEED:   r_x <= w_seed;
      ST_ITER_A: r_t <= w_t;
      ST_ITER_B: r_x <= w_prod_mid;
      default:   ;
    endcase
  end

  assign q    = r_q;
  assign iter = r_iter;

endmodule

// File: tb/tb_fdiv_newton_core.sv
// Bench for fdiv_newton_core: directed corner cases and random normalised operands on three
// parameter sets, checked against exact rational division of a by b.
`timescale 1ns/1ps
module tb_fdiv_newton_core;

  localparam int N_RAND = 1500;
  localparam logic [63:0] DIR_A [6] = '{64'hC00000, 64'h800000, 64'hFFFFFF,
                                        64'h800000, 64'hFFFFFF, 64'hAAAAAA};
  localparam logic [63:0] DIR_B [6] = '{64'h800000, 64'hFFFFFF, 64'h800000,
                                        64'h800000, 64'hFFFFFF, 64'hC00001};

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic        iv   [3];
  logic [63:0] av   [3];
  logic [63:0] bv   [3];
  logic        fl   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        bz   [3];
  logic [31:0] q24;
  logic [23:0] q16;
  logic [60:0] q53;
  logic [1:0]  it24;
  logic [1:0]  it16;
  logic [2:0]  it53;

  int n_chk  = 0;
  int n_fail = 0;

  fdiv_newton_core #(.W(24), .ITER(3)) u_dut24 (
    .clock(clock), .resetn(resetn), .in_valid(iv[0]), .in_ready(ir[0]),
    .a_frac(av[0][23:0]), .b_frac(bv[0][23:0]), .flush(fl[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .q(q24), .busy(bz[0]), .iter(it24));

  fdiv_newton_core #(.W(16), .ITER(2)) u_dut16 (
    .clock(clock), .resetn(resetn), .in_valid(iv[1]), .in_ready(ir[1]),
    .a_frac(av[1][15:0]), .b_frac(bv[1][15:0]), .flush(fl[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .q(q16), .busy(bz[1]), .iter(it16));

  fdiv_newton_core #(.W(53), .ITER(4)) u_dut53 (
    .clock(clock), .resetn(resetn), .in_valid(iv[2]), .in_ready(ir[2]),
    .a_frac(av[2][52:0]), .b_frac(bv[2][52:0]), .flush(fl[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .q(q53), .busy(bz[2]), .iter(it53));

  function automatic int w_of(input int k);
    case (k)
      0:       return 24;
      1:       return 16;
      default: return 53;
    endcase
  endfunction

  function automatic int iter_of(input int k);
    case (k)
      0:       return 3;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [63:0] q_of(input int k);
    case (k)
      0:       return {32'd0, q24};
      1:       return {40'd0, q16};
      default: return {3'd0, q53};
    endcase
  endfunction

  function automatic int it_of(input int k);
    case (k)
      0:       return int'(it24);
      1:       return int'(it16);
      default: return int'(it53);
    endcase
  endfunction

  // Closest point to qf inside the acceptance window: q[W+7:1] (W+6 fraction bits) must lie
  // within one ulp of q[W+7:8] (128 units of q[W+7:1]) of the exact quotient a/b.
  function automatic logic [127:0] q_window(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic [127:0] qf);
    logic [127:0] num, den, quo, lo, hi;
    num = {64'd0, a} << (w + 6);
    den = {64'd0, b};
    quo = num / den;
    hi  = quo + 128'd128;
    lo  = ((num % den) == 128'd0) ? quo - 128'd128 : quo - 128'd127;
    if (qf < lo) return lo;
    if (qf > hi) return hi;
    return qf;
  endfunction

  function automatic logic [63:0] rnd_frac(input int w);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r = r & ((64'd1 << w) - 64'd1);
    return r | (64'd1 << (w - 1));
  endfunction

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation on instance k; stall = cycles the consumer holds out_ready low in DONE.
  task automatic do_op(input int k, input logic [63:0] a, input logic [63:0] b,
                       input int stall, input bit with_flush, input string tag);
    int          lat;
    bit          rdy_seen;
    logic [63:0] qv;
    @(negedge clock);
    iv[k]   = 1'b1;
    av[k]   = a;
    bv[k]   = b;
    fl[k]   = with_flush;
    ordy[k] = (stall == 0);
    @(negedge clock);
    iv[k] = 1'b0;
    fl[k] = 1'b0;
    av[k] = {$urandom, $urandom};
    bv[k] = {$urandom, $urandom};
    check_val({tag, " busy"}, bz[k], 1'b1);
    lat      = 0;
    rdy_seen = 1'b0;
    while (!ov[k] && lat < 40) begin
      rdy_seen |= ir[k];
      @(negedge clock);
      lat++;
    end
    rdy_seen |= ir[k];
    check_val({tag, " latency"}, lat, 2 * iter_of(k) + 2);
    check_val({tag, " in_ready while busy"}, rdy_seen, 1'b0);
    qv = q_of(k);
    for (int i = 0; i < stall; i++) begin
      iv[k] = 1'b1;
      @(negedge clock);
      check_val({tag, " held out_valid"}, ov[k], 1'b1);
      check_val({tag, " held q"}, q_of(k), qv);
      check_val({tag, " held in_ready"}, ir[k], 1'b0);
    end
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
    check_val({tag, " iter"}, it_of(k), iter_of(k));
    check_val({tag, " q"}, qv >> 1, q_window(w_of(k), a, b, qv >> 1));
    @(negedge clock);
    check_val({tag, " idle after accept"}, {ov[k], ir[k], bz[k]}, 3'b010);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] qprev;
    bit          seen;
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      av[k]   = '0;
      bv[k]   = '0;
      fl[k]   = 1'b0;
      ordy[k] = 1'b1;
    end
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_val("reset in_ready", ir[0], 1'b1);
    check_val("reset out_valid", ov[0], 1'b0);
    check_val("reset busy", bz[0], 1'b0);
    check_val("reset q", q_of(0), 64'd0);
    check_val("reset iter", it_of(0), 0);
    check_val("reset q w53", q_of(2), 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++)
      do_op(0, DIR_A[i], DIR_B[i], 0, 1'b0, $sformatf("dir%0d", i));

    do_op(0, 64'h9A5B3C, 64'hD00F11, 5, 1'b0, "backpressure");
    do_op(0, 64'hE12345, 64'h876543, 0, 1'b1, "flush in idle");

    // Flush sampled at the third edge after acceptance.
    qprev = q_of(0);
    @(negedge clock);
    iv[0] = 1'b1;
    av[0] = 64'hB00001;
    bv[0] = 64'h900003;
    @(negedge clock);
    iv[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    fl[0] = 1'b1;
    @(negedge clock);
    fl[0] = 1'b0;
    check_val("flush busy", bz[0], 1'b0);
    check_val("flush in_ready", ir[0], 1'b1);
    seen = 1'b0;
    repeat (12) begin
      seen |= ov[0];
      @(negedge clock);
    end
    check_val("flush out_valid never", seen, 1'b0);
    check_val("flush q unchanged", q_of(0), qprev);
    do_op(0, 64'hB00001, 64'h900003, 0, 1'b0, "after flush");

    // Reset while the core sits in ITER_B (two edges after acceptance).
    @(negedge clock);
    iv[0] = 1'b1;
    av[0] = 64'hF0F0F0;
    bv[0] = 64'hA5A5A5;
    @(negedge clock);
    iv[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check_val("midop reset busy", bz[0], 1'b0);
    check_val("midop reset out_valid", ov[0], 1'b0);
    check_val("midop reset q", q_of(0), 64'd0);
    check_val("midop reset iter", it_of(0), 0);
    check_val("midop reset in_ready", ir[0], 1'b1);
    do_op(0, 64'hF0F0F0, 64'hA5A5A5, 0, 1'b0, "after reset");

    for (int k = 1; k < 3; k++) begin
      for (int n = 0; n < N_RAND; n++) begin
        logic [63:0] ra, rb;
        ra = rnd_frac(w_of(k));
        rb = rnd_frac(w_of(k));
        do_op(k, ra, rb, $urandom_range(0, 2), 1'b0, $sformatf("rand w%0d", w_of(k)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
